// File: rtl/ram_window_reader_if.sv
// rtl/ram_window_reader_if.sv - handshake and bus bundle for ram_window_reader
//
// Purpose: groups the control, RAM read and pixel stream signals of the window
// reader so they can be passed as one port.
// Signals:
//   start, base_addr                 control in (word address of byte 0)
//   busy, done, err                  status out
//   ram_rd, ram_addr                 RAM read request out
//   ram_data_out, ram_data_valid     RAM read return in
//   pix_data, pix_valid, pix_ready   byte stream with valid/ready handshake
//   pix_ch, pix_row, pix_col         coordinates of pix_data
//   pix_eol, pix_last                end of row / end of window markers
// Modports: master = reader side, slave = environment side.
interface ram_window_reader_if #(
  parameter int BAND = 64,
  parameter int AW   = 10,
  parameter int CHW  = 2,
  parameter int ROWW = 2,
  parameter int COLW = 5
);
  logic            start;
  logic [AW-1:0]   base_addr;
  logic            busy;
  logic            done;
  logic            err;
  logic            ram_rd;
  logic [AW-1:0]   ram_addr;
  logic [BAND-1:0] ram_data_out;
  logic            ram_data_valid;
  logic [7:0]      pix_data;
  logic            pix_valid;
  logic            pix_ready;
  logic [CHW-1:0]  pix_ch;
  logic [ROWW-1:0] pix_row;
  logic [COLW-1:0] pix_col;
  logic            pix_eol;
  logic            pix_last;

  modport master (
    input  start, base_addr, ram_data_out, ram_data_valid, pix_ready,
    output busy, done, err, ram_rd, ram_addr,
           pix_data, pix_valid, pix_ch, pix_row, pix_col, pix_eol, pix_last
  );

  modport slave (
    output start, base_addr, ram_data_out, ram_data_valid, pix_ready,
    input  busy, done, err, ram_rd, ram_addr,
           pix_data, pix_valid, pix_ch, pix_row, pix_col, pix_eol, pix_last
  );
endinterface

// File: rtl/ram_window_reader.sv
// rtl/ram_window_reader.sv - read-side initiator streaming a CHANNELS x ROWS x COLS byte window
//
// Purpose: fetches the window stored contiguously from base_addr in a packed byte
// RAM (LANES = BAND/8 bytes per word, byte idx = c*ROWS*COLS + r*COLS + col,
// lane = idx % LANES), unpacks each word and streams bytes in ch/row/col order.
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   bus   ram_window_reader_if.master (control, RAM read port, pixel stream)
// Optional feature: define RAM_READER_TIMEOUT_EN to abort with err when the RAM
// does not answer within TIMEOUT_CYC wait cycles; otherwise err is tied 0.
module ram_window_reader #(
  parameter int BAND        = 64,
  parameter int DEPTH       = 1024,
  parameter int CHANNELS    = 4,
  parameter int ROWS        = 3,
  parameter int COLS        = 18,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                 clk,
  input logic                 rst,
  ram_window_reader_if.master bus
);
  localparam int LANES   = BAND / 8;
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int N_BYTES = CHANNELS * ROWS * COLS;
  localparam int BW      = $clog2(N_BYTES + 1);
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ROWW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COLW    = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_base, r_word_idx;
  logic [BW-1:0]   r_byte_idx;
  logic [LW-1:0]   r_lane;
  logic [CHW-1:0]  r_ch;
  logic [ROWW-1:0] r_row;
  logic [COLW-1:0] r_col;
  logic [BAND-1:0] r_buf;

  logic            w_accept, w_hs, w_final, w_word_end, w_timeout;
  logic            w_ram_rd, w_pix_valid, w_busy, w_done;
  logic [AW:0]     w_sum;
  logic [AW-1:0]   w_addr;

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_hs       = (r_state == S_EMIT) && bus.pix_ready;
  assign w_final    = (r_byte_idx == BW'(N_BYTES - 1));
  // A word is finished after its top lane, or early on the last byte of the window
  // (the remaining lanes of the last word are discarded).
  assign w_word_end = (r_lane == LW'(LANES - 1)) || w_final;

  // Address wraps modulo DEPTH, also for non power-of-two depths.
  assign w_sum  = {1'b0, r_base} + {1'b0, r_word_idx};
  assign w_addr = (w_sum >= (AW+1)'(DEPTH)) ? AW'(w_sum - (AW+1)'(DEPTH)) : w_sum[AW-1:0];

`ifdef RAM_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_err;

  assign w_timeout = (r_state == S_WAIT) && !bus.ram_data_valid &&
                     (r_tcnt == TW'(TIMEOUT_CYC - 1));
  assign bus.err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept)       r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
      r_tcnt <= (r_state == S_WAIT) ? r_tcnt + 1'b1 : '0;
    end
  end
`else
  // Timeout disabled: WAIT blocks until the RAM answers.
  assign w_timeout = 1'b0 && (TIMEOUT_CYC > 0);
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ram_rd    = 1'b0;
    w_pix_valid = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_REQ;
      S_REQ: begin
        w_ram_rd = 1'b1;
        w_busy   = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (bus.ram_data_valid) w_next = S_EMIT;
        else if (w_timeout)     w_next = S_IDLE;
      end
      S_EMIT: begin
        w_busy      = 1'b1;
        w_pix_valid = 1'b1;
        if (w_hs && w_word_end) w_next = w_final ? S_DONE : S_REQ;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_lane     <= '0;
      r_ch       <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_buf      <= '0;
    end else begin
      if (w_accept) begin
        r_base     <= bus.base_addr;
        r_word_idx <= '0;
        r_byte_idx <= '0;
        r_lane     <= '0;
        r_ch       <= '0;
        r_row      <= '0;
        r_col      <= '0;
      end
      // Words start on a lane-0 boundary because the window begins at byte 0 of base_addr.
      if ((r_state == S_WAIT) && bus.ram_data_valid) begin
        r_buf  <= bus.ram_data_out;
        r_lane <= '0;
      end
      if (w_hs) begin
        r_byte_idx <= r_byte_idx + 1'b1;
        r_lane     <= r_lane + 1'b1;
        if (w_word_end && !w_final) r_word_idx <= r_word_idx + 1'b1;
        if (r_col == COLW'(COLS - 1)) begin
          r_col <= '0;
          if (r_row == ROWW'(ROWS - 1)) begin
            r_row <= '0;
            r_ch  <= (r_ch == CHW'(CHANNELS - 1)) ? '0 : r_ch + 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.ram_rd    = w_ram_rd;
  assign bus.ram_addr  = w_ram_rd ? w_addr : '0;
  assign bus.pix_valid = w_pix_valid;
  assign bus.pix_data  = w_pix_valid ? r_buf[{r_lane, 3'b000} +: 8] : 8'h00;
  assign bus.pix_ch    = r_ch;
  assign bus.pix_row   = r_row;
  assign bus.pix_col   = r_col;
  assign bus.pix_eol   = w_pix_valid && (r_col == COLW'(COLS - 1));
  assign bus.pix_last  = w_pix_valid && w_final;
endmodule

// File: tb/tb_ram_window_reader.sv
// tb/tb_ram_window_reader.sv - randomized self-checking bench for ram_window_reader
module tb_ram_window_reader;
  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic       pix_ready = 1'b0;
  logic       kill = 1'b0;
  logic [9:0] base_addr = '0;
  int         checks = 0;
  int         errors = 0;
  logic [63:0] mem_a [DEPTH];
  logic [63:0] mem_b [DEPTH];

  always #5 clk = ~clk;

  ram_window_reader_if #(.BAND(64), .AW(10), .CHW(2), .ROWW(2), .COLW(5)) if_a ();
  ram_window_reader_if #(.BAND(64), .AW(10), .CHW(2), .ROWW(2), .COLW(6)) if_b ();

  assign if_a.start     = start & ~sel;
  assign if_b.start     = start & sel;
  assign if_a.base_addr = base_addr;
  assign if_b.base_addr = base_addr;
  assign if_a.pix_ready = pix_ready;
  assign if_b.pix_ready = pix_ready;

  ram_window_reader #(.COLS(18)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  ram_window_reader #(.COLS(33)) u_b (.clk(clk), .rst(rst), .bus(if_b));

  // One-cycle read latency RAMs.
  always @(posedge clk) begin
    if_a.ram_data_valid <= if_a.ram_rd & ~kill;
    if_b.ram_data_valid <= if_b.ram_rd & ~kill;
    if (if_a.ram_rd) if_a.ram_data_out <= mem_a[if_a.ram_addr];
    if (if_b.ram_rd) if_b.ram_data_out <= mem_b[if_b.ram_addr];
  end

  logic       o_busy, o_done, o_err, o_rd, o_pv, o_eol, o_last;
  logic [9:0] o_addr;
  logic [7:0] o_data;
  logic [1:0] o_ch, o_row;
  logic [5:0] o_col;
  assign o_busy = sel ? if_b.busy      : if_a.busy;
  assign o_done = sel ? if_b.done      : if_a.done;
  assign o_err  = sel ? if_b.err       : if_a.err;
  assign o_rd   = sel ? if_b.ram_rd    : if_a.ram_rd;
  assign o_addr = sel ? if_b.ram_addr  : if_a.ram_addr;
  assign o_pv   = sel ? if_b.pix_valid : if_a.pix_valid;
  assign o_data = sel ? if_b.pix_data  : if_a.pix_data;
  assign o_ch   = sel ? if_b.pix_ch    : if_a.pix_ch;
  assign o_row  = sel ? if_b.pix_row   : if_a.pix_row;
  assign o_col  = sel ? if_b.pix_col   : {1'b0, if_a.pix_col};
  assign o_eol  = sel ? if_b.pix_eol   : if_a.pix_eol;
  assign o_last = sel ? if_b.pix_last  : if_a.pix_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = {$urandom, $urandom};
      mem_b[i] = {$urandom, $urandom};
    end
  endtask

  // Column-value pattern: byte k of the window holds k % cols.
  task automatic fill_pattern(input bit s, input int base);
    int n, cols, w, l;
    n    = s ? 396 : 216;
    cols = s ? 33 : 18;
    for (int k = 0; k < n; k++) begin
      w = (base + k / 8) % DEPTH;
      l = k % 8;
      if (s) mem_b[w][8*l +: 8] = 8'(k % cols);
      else   mem_a[w][8*l +: 8] = 8'(k % cols);
    end
  endtask

  function automatic logic [7:0] mem_byte(input bit s, input int base, input int k);
    int w, l;
    w = (base + k / 8) % DEPTH;
    l = k % 8;
    return s ? mem_b[w][8*l +: 8] : mem_a[w][8*l +: 8];
  endfunction

  task automatic run_window(input bit s, input int base, input int pct, input bit patt,
                            input int abort_at);
    int n, cols, nwords, k, nreads, ndone, first_rd, first_pv;
    bit stalled, fin, aborted;
    logic [7:0] held, exp_b;
    n = s ? 396 : 216;
    cols = s ? 33 : 18;
    nwords = (n + 7) / 8;
    k = 0; nreads = 0; ndone = 0; first_rd = -1; first_pv = -1;
    stalled = 0; fin = 0; aborted = 0; held = '0;
    sel = s;
    @(negedge clk);
    base_addr = 10'(base);
    start = 1'b1;
    pix_ready = ($urandom_range(0, 99) < pct);
    for (int cyc = 1; cyc <= 3000 && !fin && !aborted; cyc++) begin
      @(negedge clk);
      // start while busy must be ignored; base_addr must have been latched
      start = (cyc == 6);
      base_addr = 10'($urandom);
      pix_ready = ($urandom_range(0, 99) < pct);
      if (o_rd) begin
        if (first_rd < 0) first_rd = cyc;
        check("ram_addr", o_addr, (base + nreads) % DEPTH);
        nreads++;
      end
      if (abort_at >= 0 && o_pv && k == abort_at) begin
        aborted = 1;
      end else begin
        if (stalled) begin
          check("stall_valid", o_pv, 1);
          check("stall_data", o_data, held);
        end
        if (o_pv) begin
          if (first_pv < 0) first_pv = cyc;
          if (pix_ready) begin
            exp_b = patt ? 8'(k % cols) : mem_byte(s, base, k);
            check("pix_data", o_data, exp_b);
            check("pix_ch", o_ch, k / (3 * cols));
            check("pix_row", o_row, (k / cols) % 3);
            check("pix_col", o_col, k % cols);
            check("pix_eol", o_eol, (k % cols) == cols - 1);
            check("pix_last", o_last, k == n - 1);
            k++;
            stalled = 0;
          end else begin
            stalled = 1;
            held = o_data;
          end
        end else begin
          stalled = 0;
        end
        if (o_done) begin
          ndone++;
          check("busy_at_done", o_busy, 0);
          start = 1'b1;
          fin = 1;
        end
      end
    end
    if (aborted) begin
      rst = 1'b1;
      #1;
      check("rst_busy", o_busy, 0);
      check("rst_pix_valid", o_pv, 0);
      check("rst_pix_data", o_data, 0);
      check("rst_ram_rd", o_rd, 0);
      @(posedge clk);
      #1;
      check("rst_done", o_done, 0);
      check("rst_no_rd", o_rd, 0);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("post_rst_busy", o_busy, 0);
      check("post_rst_done", o_done, 0);
    end else begin
      check("byte_count", k, n);
      check("read_count", nreads, nwords);
      check("done_count", ndone, 1);
      check("first_rd_cycle", first_rd, 1);
      check("first_pv_cycle", first_pv, 3);
      @(negedge clk);
      start = 1'b0;
      check("idle_busy", o_busy, 0);
      check("idle_rd", o_rd, 0);
      check("done_one_cycle", o_done, 0);
      check("err_clear", o_err, 0);
      @(negedge clk);
      check("start_in_done_ignored", o_busy, 0);
    end
  endtask

`ifdef RAM_READER_TIMEOUT_EN
  task automatic timeout_test();
    int fall;
    bit saw_pv, saw_done;
    fall = -1; saw_pv = 0; saw_done = 0;
    sel = 1'b0;
    kill = 1'b1;
    @(negedge clk);
    base_addr = 10'd0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 40 && fall < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (o_pv) saw_pv = 1;
      if (o_done) saw_done = 1;
      if (!o_busy) fall = cyc;
    end
    check("timeout_cycle", fall, 18);
    check("timeout_err", o_err, 1);
    check("timeout_pv", saw_pv, 0);
    check("timeout_done", saw_done, 0);
    kill = 1'b0;
    repeat (3) @(negedge clk);
    check("timeout_err_sticky", o_err, 1);
  endtask
`endif

  initial begin
    fill_random();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset_busy", o_busy, 0);
      check("reset_done", o_done, 0);
      check("reset_err", o_err, 0);
      check("reset_ram_rd", o_rd, 0);
      check("reset_ram_addr", o_addr, 0);
      check("reset_pix_valid", o_pv, 0);
      check("reset_pix_data", o_data, 0);
      check("reset_pix_last", o_last, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    fill_pattern(0, 0);
    run_window(0, 0, 100, 1, -1);
    run_window(0, 0, 50, 1, -1);
    fill_pattern(1, 0);
    run_window(1, 0, 100, 1, -1);
    fill_pattern(0, 1020);
    run_window(0, 1020, 100, 1, -1);

    fill_random();
    run_window(0, 0, 100, 0, 100);
    run_window(0, 0, 100, 0, -1);

`ifdef RAM_READER_TIMEOUT_EN
    timeout_test();
    run_window(0, 5, 100, 0, -1);
`endif

    for (int i = 0; i < 5; i++) begin
      run_window(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(30, 100)), 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
